// File: rtl/fifo_types_pkg.sv
// Shared FIFO types.
//   word_t        : one FIFO word
//   pack_state_e  : state of the word-to-beat packer
//   lane_mask(n)  : (1<<n)-1, the low n lanes set
package fifo_types_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    PACK_FILL = 1'b0,
    PACK_HOLD = 1'b1
  } pack_state_e;

  function automatic logic [31:0] lane_mask(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/fifo_pack_reader.sv
// Drains a FIFO through its valid/yumi handshake and packs WORDS_PER_BEAT
// consecutive words into one wide beat. The beat is offered downstream on
// valid/ready. flush_i closes a partial beat early, with mask_o marking
// which lanes carry data.
//
// Ports
//   clk      : clock, all logic on posedge
//   reset_n  : synchronous reset, active-high (1 = in reset)
//   valid_i  : FIFO head word available
//   data_i   : FIFO head word
//   yumi_o   : word consumed this cycle (combinational)
//   flush_i  : close the current partial beat
//   valid_o  : packed beat valid
//   data_o   : packed beat, lane 0 in the LSBs
//   mask_o   : per-lane valid mask
//   ready_i  : downstream accepts the beat
//   count_o  : words held in the current beat
module fifo_pack_reader
  import fifo_types_pkg::*;
#(
  parameter int WORDS_PER_BEAT = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               valid_i,
  input  word_t                              data_i,
  output logic                               yumi_o,
  input  logic                               flush_i,
  output logic                               valid_o,
  output logic [WORDS_PER_BEAT*WORD_W-1:0]   data_o,
  output logic [WORDS_PER_BEAT-1:0]          mask_o,
  input  logic                               ready_i,
  output logic [$clog2(WORDS_PER_BEAT+1)-1:0] count_o
);

  localparam int CNT_W = $clog2(WORDS_PER_BEAT + 1);
  localparam int IDX_W = $clog2(WORDS_PER_BEAT);

  pack_state_e               state, state_nxt;
  logic [CNT_W-1:0]          count, count_nxt;
  logic [CNT_W-1:0]          cnt_post;
  logic [WORDS_PER_BEAT-1:0] mask, mask_nxt;
  word_t                     lanes [WORDS_PER_BEAT];
  logic                      accept;

  // Consumption never looks at ready_i; HOLD alone blocks further writes.
  assign yumi_o   = valid_i & (state == PACK_FILL) & ~reset_n;
  assign cnt_post = count + CNT_W'(yumi_o);
  assign accept   = (state == PACK_HOLD) & ready_i;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    mask_nxt  = mask;
    unique case (state)
      PACK_FILL: begin
        count_nxt = cnt_post;
        // A full beat and a flush with data both close the beat; the mask
        // covers exactly the words held after this cycle's yumi.
        if ((cnt_post == CNT_W'(WORDS_PER_BEAT)) ||
            (flush_i && (cnt_post != '0))) begin
          state_nxt = PACK_HOLD;
          mask_nxt  = WORDS_PER_BEAT'(lane_mask(32'(cnt_post)));
        end
      end
      PACK_HOLD: begin
        if (ready_i) begin
          state_nxt = PACK_FILL;
          count_nxt = '0;
          mask_nxt  = '0;
        end
      end
      default: state_nxt = PACK_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state <= PACK_FILL;
      count <= '0;
      mask  <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      mask  <= mask_nxt;
    end
  end

  // Lanes are cleared on every beat hand-off so unfilled lanes of the
  // next partial beat read zero.
  always_ff @(posedge clk) begin
    if (reset_n || accept) begin
      for (int k = 0; k < WORDS_PER_BEAT; k++) lanes[k] <= '0;
    end else if (yumi_o) begin
      lanes[count[IDX_W-1:0]] <= data_i;
    end
  end

  always_comb begin
    data_o = '0;
    for (int k = 0; k < WORDS_PER_BEAT; k++) data_o[k*WORD_W +: WORD_W] = lanes[k];
  end

  assign valid_o = (state == PACK_HOLD);
  assign mask_o  = mask;
  assign count_o = count;

endmodule

// File: tb/tb_fifo_pack_reader.sv
module tb_fifo_pack_reader;
  import fifo_types_pkg::*;

  localparam int W  = 4;
  localparam int DW = W * WORD_W;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          valid_i;
  word_t         data_i;
  logic          yumi_o;
  logic          flush_i;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic [W-1:0]  mask_o;
  logic          ready_i;
  logic [2:0]    count_o;

  int checks   = 0;
  int failures = 0;
  int beats    = 0;

  // Reference model: the words collected for the beat under construction,
  // and whether that beat is currently being offered downstream.
  word_t m_words[$];
  bit    m_hold;

  always #5 clk = ~clk;

  fifo_pack_reader #(.WORDS_PER_BEAT(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .valid_i (valid_i),
    .data_i  (data_i),
    .yumi_o  (yumi_o),
    .flush_i (flush_i),
    .valid_o (valid_o),
    .data_o  (data_o),
    .mask_o  (mask_o),
    .ready_i (ready_i),
    .count_o (count_o)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic [DW-1:0] e_data;
    logic [W-1:0]  e_mask;
    e_data = '0;
    e_mask = '0;
    for (int k = 0; k < W; k++) begin
      if (k < m_words.size()) begin
        e_data[k*WORD_W +: WORD_W] = m_words[k];
        if (m_hold) e_mask[k] = 1'b1;
      end
    end
    check("valid_o", DW'(valid_o), DW'(m_hold));
    check("data_o",  data_o, e_data);
    check("mask_o",  DW'(mask_o), DW'(e_mask));
    check("count_o", DW'(count_o), DW'(m_words.size()));
  endtask

  // One clock cycle: apply inputs, check yumi, advance model and DUT, check outputs.
  task automatic step(input logic r, input logic v, input logic f, input logic rdy, input word_t d);
    logic e_yumi;
    reset_n = r; valid_i = v; flush_i = f; ready_i = rdy; data_i = d;
    #1;
    e_yumi = v && !m_hold && !r;
    check("yumi_o", DW'(yumi_o), DW'(e_yumi));
    @(posedge clk);
    if (r) begin
      m_words.delete();
      m_hold = 1'b0;
    end else if (m_hold) begin
      if (rdy) begin
        m_words.delete();
        m_hold = 1'b0;
        beats++;
      end
    end else begin
      if (e_yumi) m_words.push_back(d);
      if (m_words.size() == W || (f && m_words.size() > 0)) m_hold = 1'b1;
    end
    #1;
    compare_outputs();
  endtask

  initial begin
    reset_n = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0; data_i = '0;
    m_hold = 1'b0;
    @(posedge clk); #1;

    // Reset with valid_i high.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, word_t'(16'h5555));
    check("reset_data_lit", data_o, '0);

    // Full beat.
    step(0, 1, 0, 1, 16'h0011);
    step(0, 1, 0, 1, 16'h0022);
    step(0, 1, 0, 1, 16'h0033);
    step(0, 1, 0, 1, 16'h0044);
    check("full_data_lit", data_o, 64'h0044_0033_0022_0011);
    check("full_mask_lit", DW'(mask_o), DW'(4'b1111));
    step(0, 1, 0, 1, 16'h0055);          // accepted, yumi blocked this cycle
    check("after_accept_cnt_lit", DW'(count_o), '0);
    step(0, 0, 0, 1, 16'h0000);          // yumi resumes (checked by step: valid_i=0 here)
    check("resume_cnt_lit", DW'(count_o), '0);

    // Backpressure.
    step(0, 1, 0, 0, 16'h0101);
    step(0, 1, 0, 0, 16'h0202);
    step(0, 1, 0, 0, 16'h0303);
    step(0, 1, 0, 0, 16'h0404);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 16'hdead);
    check("bp_data_lit", data_o, 64'h0404_0303_0202_0101);
    step(0, 0, 0, 1, 16'h0000);
    step(0, 0, 0, 1, 16'h0000);
    check("bp_once_cnt_lit", DW'(count_o), '0);

    // Partial flush.
    step(0, 1, 0, 0, 16'h00a1);
    step(0, 1, 0, 0, 16'h00a2);
    step(0, 0, 1, 0, 16'h0000);
    check("partial_data_lit", data_o, 64'h0000_0000_00a2_00a1);
    check("partial_mask_lit", DW'(mask_o), DW'(4'b0011));
    step(0, 0, 0, 1, 16'h0000);

    // Flush together with the 3rd yumi.
    step(0, 1, 0, 0, 16'h00b1);
    step(0, 1, 0, 0, 16'h00b2);
    step(0, 1, 1, 0, 16'h00b3);
    check("flush3_mask_lit", DW'(mask_o), DW'(4'b0111));
    check("flush3_data_lit", data_o, 64'h0000_00b3_00b2_00b1);
    step(0, 0, 0, 1, 16'h0000);

    // Flush with nothing held.
    step(0, 0, 1, 1, 16'h0000);
    check("flush_empty_valid_lit", DW'(valid_o), '0);

    // Reset while a beat is held.
    step(0, 1, 0, 0, 16'h00c1);
    step(0, 1, 0, 0, 16'h00c2);
    step(0, 1, 0, 0, 16'h00c3);
    step(0, 1, 0, 0, 16'h00c4);
    step(1, 1, 0, 0, 16'h0000);
    check("rst_hold_valid_lit", DW'(valid_o), '0);
    step(0, 1, 0, 0, 16'h00d1);
    step(0, 1, 0, 0, 16'h00d2);
    step(0, 1, 0, 0, 16'h00d3);
    step(0, 1, 0, 0, 16'h00d4);
    check("fresh_data_lit", data_o, 64'h00d4_00d3_00d2_00d1);
    step(0, 0, 0, 1, 16'h0000);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) == 0), ($urandom_range(3) != 0), ($urandom_range(7) == 0),
           ($urandom_range(1) == 1), word_t'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
